// File: rtl/rx_frame_sequencer_if.sv
// rtl/rx_frame_sequencer_if.sv - CPU-side character interface of the serial receive sequencer.
// break_det exists only when RX_BREAK_DETECT_EN is defined.
interface rx_frame_sequencer_if #(
  parameter int DATA_BITS = 7
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ack;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;
`ifdef RX_BREAK_DETECT_EN
  logic                 break_det;
`endif

  modport master (
    input  rx_ack,
`ifdef RX_BREAK_DETECT_EN
    output break_det,
`endif
    output rx_data, rx_valid, parity_err, frame_err, overrun
  );

  modport slave (
    output rx_ack,
`ifdef RX_BREAK_DETECT_EN
    input  break_det,
`endif
    input  rx_data, rx_valid, parity_err, frame_err, overrun
  );
endinterface

// File: rtl/rx_frame_sequencer.sv
// rtl/rx_frame_sequencer.sv - 16x oversampled serial receiver with even parity and a one-character holding register.
// Optional break detection output is enabled by defining RX_BREAK_DETECT_EN.
module rx_frame_sequencer #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  data_in,
  output logic                  busy,
  rx_frame_sequencer_if.master  cpu
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_FULL = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           sync_q;
  logic [TW-1:0]        tick_q;
  logic [BW-1:0]        bit_cnt_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic                 par_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 perr_q;
  logic                 ferr_q;
  logic                 ovr_q;

  logic ls;
  logic sample;
  logic complete;
  logic tick_clr;
  logic load;
  logic drop;
  logic ack;

  assign ls = sync_q[1];

  always_comb begin
    state_d  = state_q;
    sample   = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!ls) state_d = START;
      end
      START: begin
        if (tick_q == TICK_HALF) begin
          sample  = 1'b1;
          state_d = ls ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick_q == TICK_FULL) begin
          sample = 1'b1;
          if (bit_cnt_q == BIT_LAST) state_d = PARITY;
        end
      end
      PARITY: begin
        if (tick_q == TICK_FULL) begin
          sample  = 1'b1;
          state_d = STOP;
        end
      end
      STOP: begin
        if (tick_q == TICK_FULL) begin
          sample   = 1'b1;
          complete = 1'b1;
          state_d  = ls ? IDLE : WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        if (ls) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The tick counter restarts on every state entry and every sample point.
  assign tick_clr = sample || (state_d != state_q) || (state_q == IDLE);
  assign ack      = cpu.rx_ack && valid_q;
  assign load     = complete && (!valid_q || cpu.rx_ack);
  assign drop     = complete && !load;

`ifdef RX_BREAK_DETECT_EN
  logic brk_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      brk_q <= 1'b0;
    end else if (load) begin
      brk_q <= (shreg_q == '0) && !par_q && !ls;
    end else if (ack) begin
      brk_q <= 1'b0;
    end
  end
  assign cpu.break_det = brk_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      sync_q    <= 2'b11;
      tick_q    <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[0], data_in};
      tick_q  <= tick_clr ? '0 : tick_q + TW'(1);

      if (state_q == START) begin
        bit_cnt_q <= '0;
      end else if (sample && state_q == DATA) begin
        bit_cnt_q <= bit_cnt_q + BW'(1);
      end

      if (sample && state_q == DATA) shreg_q <= {ls, shreg_q[DATA_BITS-1:1]};
      if (sample && state_q == PARITY) par_q <= ls;

      // A load also satisfies any ack in the same cycle, so overrun restarts clear.
      if (load) begin
        data_q  <= shreg_q;
        valid_q <= 1'b1;
        perr_q  <= ^{shreg_q, par_q};
        ferr_q  <= !ls;
        ovr_q   <= 1'b0;
      end else if (drop) begin
        ovr_q <= 1'b1;
      end else if (ack) begin
        valid_q <= 1'b0;
        perr_q  <= 1'b0;
        ferr_q  <= 1'b0;
        ovr_q   <= 1'b0;
      end
    end
  end

  assign busy           = (state_q != IDLE);
  assign cpu.rx_data    = data_q;
  assign cpu.rx_valid   = valid_q;
  assign cpu.parity_err = perr_q;
  assign cpu.frame_err  = ferr_q;
  assign cpu.overrun    = ovr_q;

endmodule

// File: tb/tb_rx_frame_sequencer.sv
// tb/tb_rx_frame_sequencer.sv - Self-checking bench for rx_frame_sequencer; honours RX_BREAK_DETECT_EN.
module tb_rx_frame_sequencer;
  localparam int OS      = 16;
  localparam int LATENCY = 2 + OS / 2 + OS * (7 + 2);

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic data_in = 1'b1;
  logic busy;

  rx_frame_sequencer_if #(.DATA_BITS(7)) cpu_if ();

  rx_frame_sequencer #(.OVERSAMPLE(OS), .DATA_BITS(7)) dut (
    .clk     (clk),
    .reset   (reset),
    .data_in (data_in),
    .busy    (busy),
    .cpu     (cpu_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         at;
    logic [6:0] d;
    logic       p;
    logic       s;
  } exp_t;

  exp_t pending[$];
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int first_valid_edge = -1;

  logic       m_valid = 1'b0;
  logic [6:0] m_data = '0;
  logic       m_perr = 1'b0;
  logic       m_ferr = 1'b0;
  logic       m_ovr = 1'b0;
  logic       m_brk = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Holding-register model: frames complete a fixed latency after their start bit.
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      pending.delete();
      m_valid = 0; m_data = '0; m_perr = 0; m_ferr = 0; m_ovr = 0; m_brk = 0;
    end else if (pending.size() > 0 && pending[0].at == cyc) begin
      exp_t e;
      e = pending.pop_front();
      if (!m_valid || cpu_if.rx_ack) begin
        m_valid = 1;
        m_data  = e.d;
        m_perr  = ^{e.d, e.p};
        m_ferr  = !e.s;
        m_ovr   = 0;
        m_brk   = (e.d == 0) && !e.p && !e.s;
      end else begin
        m_ovr = 1;
      end
    end else if (cpu_if.rx_ack && m_valid) begin
      m_valid = 0; m_perr = 0; m_ferr = 0; m_ovr = 0; m_brk = 0;
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      check("model", {20'd0, cpu_if.rx_valid, cpu_if.parity_err, cpu_if.frame_err,
                      cpu_if.overrun, 1'b0, cpu_if.rx_data},
                     {20'd0, m_valid, m_perr, m_ferr, m_ovr, 1'b0, m_data});
`ifdef RX_BREAK_DETECT_EN
      check("model_break", {31'd0, cpu_if.break_det}, {31'd0, m_brk});
`endif
      if (cpu_if.rx_valid && first_valid_edge < 0) first_valid_edge = cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [6:0] d, input logic p, input logic s);
    logic [9:0] bits;
    bits = {s, p, d, 1'b0};
    pending.push_back('{at: cyc + 1 + LATENCY, d: d, p: p, s: s});
    for (int i = 0; i < 10; i++) begin
      data_in = bits[i];
      tick(OS);
    end
  endtask

  task automatic ack_pulse();
    cpu_if.rx_ack = 1'b1;
    tick(1);
    cpu_if.rx_ack = 1'b0;
  endtask

  int e0_first;

  initial begin
    cpu_if.rx_ack = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(100);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_valid", {31'd0, cpu_if.rx_valid}, 32'd0);

    e0_first = cyc + 1;
    send(7'h4B, 1'b0, 1'b1);
    send(7'h0D, 1'b1, 1'b1);
    check("latency", first_valid_edge, e0_first + 154);
    check("first_data", {25'd0, cpu_if.rx_data}, 32'h4B);
    check("overrun_set", {31'd0, cpu_if.overrun}, 32'd1);
    check("overrun_perr", {31'd0, cpu_if.parity_err}, 32'd0);
    ack_pulse();
    tick(2);
    check("ack_clears", {28'd0, cpu_if.rx_valid, cpu_if.parity_err, cpu_if.frame_err,
                         cpu_if.overrun}, 32'd0);

    send(7'h0D, 1'b0, 1'b1);
    check("perr_data", {25'd0, cpu_if.rx_data}, 32'h0D);
    check("perr_flag", {31'd0, cpu_if.parity_err}, 32'd1);
    ack_pulse();

    send(7'h4B, 1'b0, 1'b0);
    tick(30);
    check("wait_high_busy", {31'd0, busy}, 32'd1);
    check("ferr_flag", {31'd0, cpu_if.frame_err}, 32'd1);
    data_in = 1'b1;
    tick(5);
    check("wait_high_exit", {31'd0, busy}, 32'd0);
    ack_pulse();

    send(7'h00, 1'b0, 1'b0);
    tick(5);
    data_in = 1'b1;
    tick(5);
    check("break_ferr", {31'd0, cpu_if.frame_err}, 32'd1);
    check("break_perr", {31'd0, cpu_if.parity_err}, 32'd0);
`ifdef RX_BREAK_DETECT_EN
    check("break_det", {31'd0, cpu_if.break_det}, 32'd1);
`endif
    ack_pulse();

    data_in = 1'b0;
    tick(5);
    data_in = 1'b1;
    tick(3);
    check("glitch_start", {31'd0, busy}, 32'd1);
    tick(10);
    check("glitch_abort", {31'd0, busy}, 32'd0);
    check("glitch_valid", {31'd0, cpu_if.rx_valid}, 32'd0);

    data_in = 1'b0;
    tick(OS);
    data_in = 1'b1; tick(OS);
    data_in = 1'b0; tick(OS);
    data_in = 1'b1; tick(OS);
    check("mid_frame_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    check("reset_busy", {31'd0, busy}, 32'd0);
    tick(5);
    send(7'h0D, 1'b1, 1'b1);
    tick(3);
    check("post_reset", {25'd0, cpu_if.rx_valid, cpu_if.parity_err, cpu_if.frame_err,
                         cpu_if.overrun, cpu_if.rx_data[2:0]}, {25'd0, 4'b1000, 3'b101});
    check("post_reset_data", {25'd0, cpu_if.rx_data}, 32'h0D);
    ack_pulse();
    ack_pulse();
    tick(3);
    check("final_valid", {31'd0, cpu_if.rx_valid}, 32'd0);
    check("final_busy", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
